ghost_scheduler: RTL
====================

# ghost_scheduler

Time-multiplexes one shared ghost direction unit across `NUM_GHOSTS` ghosts. It owns every ghost's position and last-direction registers. On each game-step tick it runs one round: present ghost k's state, wait `SETTLE` cycles, capture the returned direction, then advance ghost k by `STEP` pixels. It sits between the game-step timer and the sprite renderer; the direction unit's Pac-Man position inputs are wired directly, not through this block.

## Interface
- `NUM_GHOSTS`, 4, number of ghosts served per round (1..8)
- `SETTLE`, 3, cycles between operand presentation and direction capture (1..15)
- `STEP`, 1, pixels moved per valid direction (1..8)
- `X_MAX`, 639, largest legal x coordinate
- `Y_MAX`, 479, largest legal y coordinate
- `HOME_X0`, 280, reset x of ghost 0; ghost i resets to `HOME_X0 + 20*i`
- `HOME_Y`, 240, reset y of all ghosts
- `clk`  in  1  single system clock
- `rst`  in  1  synchronous, active-high reset
- `step_tick`  in  1  one-cycle pulse requesting a round
- `freeze`  in  1  when high, `step_tick` is ignored
- `ghost_dir_in`  in  4  one-hot direction from the shared unit
- `ghost_sel_x`  out  11  x of the ghost being served
- `ghost_sel_y`  out  10  y of the ghost being served
- `ghost_sel_prev_dir`  out  4  stored direction of the ghost being served
- `ghost_pos_x_all`  out  11*NUM_GHOSTS  packed x positions, ghost i at bits [11i+10:11i]
- `ghost_pos_y_all`  out  10*NUM_GHOSTS  packed y positions
- `ghost_dir_all`  out  4*NUM_GHOSTS  packed stored directions
- `busy`  out  1  high in any state other than IDLE
- `round_done`  out  1  one-cycle pulse at the end of each round
- `overrun`  out  1  sticky; set when a tick is dropped

## Operation
- Direction encoding: RIGHT=0001, UP=0010, DOWN=0100, LEFT=1000, NONE=0000.
- Reset values:
  - ghost i is at (`HOME_X0+20i`, `HOME_Y`) with direction 0000.
  - Index register = 0; state = IDLE.
  - `busy`, `round_done`, `overrun`, and the pending flag are all 0.
  - `ghost_sel_*` show ghost 0.
- `ghost_sel_*` are always the registers of the current index. They stay stable from LOAD through CAPTURE.
- States:
  - IDLE: if (`step_tick` or pending) and not `freeze`, clear pending, set index = 0, go to LOAD.
  - LOAD: 1 cycle; operands are presented; go to WAIT.
  - WAIT: counts `SETTLE` cycles, then goes to CAPTURE.
  - CAPTURE: 1 cycle; sample `ghost_dir_in` and update ghost[index]. If index = `NUM_GHOSTS-1`, go to DONE; otherwise increment index and go to LOAD.
  - DONE: 1 cycle; `round_done`=1; set index to 0; go to IDLE.
- Update rule in CAPTURE:
  - RIGHT: x = min(x+STEP, X_MAX)
  - LEFT: x = max(x-STEP, 0)
  - UP: y = max(y-STEP, 0)
  - DOWN: y = min(y+STEP, Y_MAX)
  - The stored direction becomes `ghost_dir_in`.
  - If `ghost_dir_in` is not one-hot (zero or multi-bit), position and direction are unchanged.
- Arithmetic is unsigned at one bit wider than the coordinate, then clamped. No wrap-around.
- `step_tick` while `busy` (including DONE): set pending. If pending is already set, the tick is dropped and `overrun` is set.
- `overrun` clears only on `rst`.
- `freeze` is evaluated only in IDLE. A frozen tick is discarded: pending is not set and `overrun` is not affected. Pending is retained while frozen.
- `rst` asserted in any state returns all registers to reset values on that edge. A round in progress is abandoned and no `round_done` is produced.

## Timing
- Per ghost: SETTLE+2 cycles. Round: NUM_GHOSTS*(SETTLE+2)+1 cycles from the IDLE→LOAD edge to the DONE→IDLE edge. With defaults this is 21 cycles.
- Tick sampled at edge E0:
  - `busy`=1 from E0.
  - Ghost k is presented from E0+k(SETTLE+2).
  - `ghost_dir_in` is sampled and position updated at E0+k(SETTLE+2)+SETTLE+2.
  - `round_done` is high for the cycle after the last CAPTURE edge.
- With pending set, the next round starts on the edge leaving DONE+IDLE. There is 1 IDLE cycle between rounds.
- Packed outputs change only on CAPTURE edges and reset.

## Test plan
- Reset, no ticks: ghost positions (280,240), (300,240), (320,240), (340,240); all dirs 0; `busy`=0; `ghost_sel_x`=280.
- One tick, `ghost_dir_in` held RIGHT: `round_done` on cycle 21; all x +1; all dirs 0001; `ghost_sel_*` stable across each 5-cycle slot.
- Ghost 0 at x=0 with LEFT: x stays 0. Ghost 3 at y=479 with DOWN: y stays 479. `ghost_dir_in`=0110: no change.
- Ticks at cycles 0, 5 and 10: two rounds run back-to-back, separated by 1 IDLE cycle; the third tick sets `overrun`=1, which persists until `rst`.
- `freeze`=1 plus a tick: no round and `busy` stays 0. `rst` at cycle 8 of a round: all outputs at reset values next cycle; no `round_done`.

Source files
------------

// File: rtl/ghost_scheduler.sv
// Round-robin scheduler that shares one ghost direction unit across all ghosts,
// owning their positions and last directions and stepping each ghost once per round.
module ghost_scheduler #(
    parameter int NUM_GHOSTS = 4,
    parameter int SETTLE     = 3,
    parameter int STEP       = 1,
    parameter int X_MAX      = 639,
    parameter int Y_MAX      = 479,
    parameter int HOME_X0    = 280,
    parameter int HOME_Y     = 240
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step_tick,
    input  logic                    freeze,
    input  logic [3:0]              ghost_dir_in,
    output logic [10:0]             ghost_sel_x,
    output logic [9:0]              ghost_sel_y,
    output logic [3:0]              ghost_sel_prev_dir,
    output logic [11*NUM_GHOSTS-1:0] ghost_pos_x_all,
    output logic [10*NUM_GHOSTS-1:0] ghost_pos_y_all,
    output logic [4*NUM_GHOSTS-1:0]  ghost_dir_all,
    output logic                    busy,
    output logic                    round_done,
    output logic                    overrun
);

    localparam int IW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;

    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, CAPTURE, DONE} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   idx;
    logic [3:0]      cnt;
    logic            pending;
    logic            start;
    logic            last;

    logic [10:0]     gx [NUM_GHOSTS];
    logic [9:0]      gy [NUM_GHOSTS];
    logic [3:0]      gd [NUM_GHOSTS];

    // Coordinates are widened by one bit so the sum/difference never wraps before clamping.
    function automatic logic [11:0] sat_inc(input logic [11:0] v, input logic [11:0] lim);
        logic [11:0] s;
        s = v + 12'(STEP);
        return (s > lim) ? lim : s;
    endfunction

    function automatic logic [11:0] sat_dec(input logic [11:0] v);
        return (v < 12'(STEP)) ? 12'd0 : v - 12'(STEP);
    endfunction

    assign last       = (idx == IW'(NUM_GHOSTS - 1));
    assign busy       = (state != IDLE);
    assign round_done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        start   = 1'b0;
        case (state)
            IDLE: begin
                if ((step_tick || pending) && !freeze) begin
                    state_n = LOAD;
                    start   = 1'b1;
                end
            end
            LOAD:    state_n = WAIT;
            WAIT:    if (cnt == 4'(SETTLE - 1)) state_n = CAPTURE;
            CAPTURE: state_n = last ? DONE : LOAD;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // A tick arriving while busy is queued once; a second one is lost and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            cnt     <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (state == LOAD) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 4'd1;
            end

            if (start || state == DONE) begin
                idx <= '0;
            end else if (state == CAPTURE && !last) begin
                idx <= idx + IW'(1);
            end

            if (start) begin
                pending <= 1'b0;
            end else if (step_tick && state != IDLE) begin
                if (pending) begin
                    overrun <= 1'b1;
                end else begin
                    pending <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                gx[i] <= 11'(HOME_X0 + 20 * i);
                gy[i] <= 10'(HOME_Y);
                gd[i] <= 4'b0000;
            end
        end else if (state == CAPTURE && $onehot(ghost_dir_in)) begin
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                if (idx == IW'(i)) begin
                    gd[i] <= ghost_dir_in;
                    case (ghost_dir_in)
                        DIR_RIGHT: gx[i] <= 11'(sat_inc({1'b0, gx[i]}, 12'(X_MAX)));
                        DIR_LEFT:  gx[i] <= 11'(sat_dec({1'b0, gx[i]}));
                        DIR_UP:    gy[i] <= 10'(sat_dec({2'b00, gy[i]}));
                        DIR_DOWN:  gy[i] <= 10'(sat_inc({2'b00, gy[i]}, 12'(Y_MAX)));
                        default:   gd[i] <= gd[i];
                    endcase
                end
            end
        end
    end

    always_comb begin
        ghost_sel_x        = gx[0];
        ghost_sel_y        = gy[0];
        ghost_sel_prev_dir = gd[0];
        for (int i = 1; i < NUM_GHOSTS; i++) begin
            if (idx == IW'(i)) begin
                ghost_sel_x        = gx[i];
                ghost_sel_y        = gy[i];
                ghost_sel_prev_dir = gd[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_pack
        assign ghost_pos_x_all[11*g +: 11] = gx[g];
        assign ghost_pos_y_all[10*g +: 10] = gy[g];
        assign ghost_dir_all[4*g +: 4]     = gd[g];
    end

endmodule
